// File: rtl/mem_port_arbiter_if.sv
// Bundles the requestor-side and cache-side signals of the N-port memory arbiter.
// The slave modport is the arbiter; master is whatever drives requests and cache responses.
interface mem_port_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MASK_WIDTH = 2
);
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_PORTS*MASK_WIDTH-1:0] req_wmask;
    logic [NUM_PORTS-1:0]            req_resp;
    logic [DATA_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            grant;
    logic                            busy;
    logic                            mem_read;
    logic                            mem_write;
    logic [ADDR_WIDTH-1:0]           mem_address;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [MASK_WIDTH-1:0]           mem_byte_enable;
    logic                            mem_resp;
    logic [DATA_WIDTH-1:0]           mem_rdata;

    modport master (
        output req_read, req_write, req_address, req_wdata, req_wmask, mem_resp, mem_rdata,
        input  req_resp, req_rdata, grant, busy, mem_read, mem_write, mem_address, mem_wdata,
               mem_byte_enable
    );

    modport slave (
        input  req_read, req_write, req_address, req_wdata, req_wmask, mem_resp, mem_rdata,
        output req_resp, req_rdata, grant, busy, mem_read, mem_write, mem_address, mem_wdata,
               mem_byte_enable
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises N requestor ports onto one cache port with a registered grant held for the
// whole transaction; fixed-priority or round-robin selection.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MASK_WIDTH = 2,
    parameter int unsigned RR_MODE    = 0
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   read_q, read_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]  mask_q, mask_d;

    logic [NUM_PORTS-1:0]   active;
    logic [IDX_W-1:0]       fix_idx, rr_idx, win_idx, gnt_idx;
    int unsigned            j;

    // Winner selection and encoding of the held grant.
    always_comb begin
        active  = bus.req_read | bus.req_write;
        fix_idx = '0;
        rr_idx  = '0;
        gnt_idx = '0;
        j       = 0;
        // Descending scans so the last hit is the lowest index / nearest to the pointer.
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (active[i]) fix_idx = IDX_W'(i);
        end
        for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % NUM_PORTS;
            if (active[j]) rr_idx = IDX_W'(j);
        end
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (grant_q[i]) gnt_idx = IDX_W'(i);
        end
        win_idx = (RR_MODE != 0) ? rr_idx : fix_idx;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        unique case (state_q)
            StIdle: begin
                if (|active) begin
                    state_d = StBusy;
                    grant_d = NUM_PORTS'(1) << win_idx;
                    write_d = bus.req_write[win_idx];
                    read_d  = bus.req_read[win_idx] & ~bus.req_write[win_idx];
                    addr_d  = bus.req_address[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    mask_d  = bus.req_wmask[int'(win_idx)*MASK_WIDTH +: MASK_WIDTH];
                end
            end
            StBusy: begin
                if (bus.mem_resp) begin
                    state_d = StIdle;
                    grant_d = '0;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (RR_MODE != 0) ptr_d = IDX_W'((int'(gnt_idx) + 1) % NUM_PORTS);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    // Gate with reset so an abandoned access never completes on the requestor side.
    assign bus.req_resp = grant_q &
                          {NUM_PORTS{bus.mem_resp & (state_q == StBusy) & ~reset}};
    assign bus.req_rdata       = bus.mem_rdata;
    assign bus.grant           = grant_q;
    assign bus.busy            = (state_q == StBusy);
    assign bus.mem_read        = read_q;
    assign bus.mem_write       = write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = mask_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port arbiter that serialises read/write requests from several pipeline requestors (fetch, mem, future prefetch/DMA) onto the single unified cache port.
- Successor to the fixed two-port fetch/mem arbiter: generalised port count and widths, selectable fixed or round-robin priority, a registered grant held for the whole transaction, and per-port response routing.
- Sits between the pipeline stages and the L1 cache.

Parameters:
- NUM_PORTS, 2, number of requestor ports (2..8); port 0 = highest fixed priority.
- ADDR_WIDTH, 16, request/memory address width.
- DATA_WIDTH, 16, read/write data width.
- MASK_WIDTH, 2, byte-enable width (DATA_WIDTH/8).
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_PORTS  per-port read request, held until matching req_resp.
- req_write  in  NUM_PORTS  per-port write request, held until matching req_resp.
- req_address  in  NUM_PORTS*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- req_wmask  in  NUM_PORTS*MASK_WIDTH  packed byte enables.
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port.
- req_rdata  out  DATA_WIDTH  read data broadcast to all ports; valid only with req_resp.
- grant  out  NUM_PORTS  one-hot registered grant; all-zero when idle.
- busy  out  1  high while a transaction is outstanding.
- mem_read  out  1  read strobe to cache.
- mem_write  out  1  write strobe to cache.
- mem_address  out  ADDR_WIDTH  latched address.
- mem_wdata  out  DATA_WIDTH  latched write data.
- mem_byte_enable  out  MASK_WIDTH  latched byte enables.
- mem_resp  in  1  cache completion.
- mem_rdata  in  DATA_WIDTH  cache read data.

Behaviour:
- Reset: state IDLE; grant=0, busy=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, mem_byte_enable=0, rr pointer=0. req_resp=0 during the reset cycle even if mem_resp=1.
- Reset mid-transaction abandons the outstanding access. No resp is issued, and the cache is reset alongside.
- Port i is "active" when req_read[i] | req_write[i].
- If both are high on the same port, write takes precedence (mem_write=1, mem_read=0).
- FSM IDLE:
  - No active port: stay.
  - Otherwise pick a winner. Fixed mode: lowest active index. RR mode: first active index searching upward from the pointer, wrapping NUM_PORTS-1 -> 0.
  - At the edge, register the winner's grant, address, wdata, mask and op, and go to BUSY.
- Latency: a request sampled at edge k drives mem_read/mem_write from cycle k+1. Minimum transaction is 2 cycles (grant cycle plus one cycle with mem_resp).
- FSM BUSY:
  - All mem_* outputs are held constant from the latched values. Requestor input changes are ignored.
  - req_resp = grant & {NUM_PORTS{mem_resp}} (combinational, same cycle). req_rdata = mem_rdata (pass-through).
  - On mem_resp: next state IDLE, strobes cleared, grant=0. In RR mode the pointer becomes (granted index + 1) mod NUM_PORTS. In fixed mode the pointer is unused.
- The completed port must drop its request in the cycle after req_resp or present a new one. IDLE re-arbitrates the next cycle, so back-to-back transactions have 1 idle cycle (grant gap).
- busy = (state == BUSY). Pipeline stall logic uses busy & ~mem_resp.
- No starvation in RR mode: a continuously requesting port waits at most NUM_PORTS-1 transactions.
- mem_resp in IDLE is ignored; no req_resp is generated.

Test Plan:
- Single read: NUM_PORTS=2, port1 read addr 0x1234, mem_resp after 3 cycles with rdata 0xBEEF -> grant=2'b10 next cycle, mem_read=1, mem_address=0x1234 held 3 cycles, req_resp=2'b10 and req_rdata=0xBEEF in the resp cycle, busy falls the next cycle.
- Fixed priority: RR_MODE=0, ports 0 and 1 request simultaneously and keep requesting -> port0 granted every transaction and port1 never granted while port0 requests.
- Round-robin: RR_MODE=1, NUM_PORTS=4, all ports requesting continuously -> grant sequence 0,1,2,3,0 with one idle cycle between grants.
- Write plus conflict: port0 asserts read and write together, addr 0x0040, wdata 0x00FF, wmask 2'b01 -> mem_write=1, mem_read=0, mem_wdata=0x00FF, mem_byte_enable=2'b01.
- Input stability: during BUSY, change port0 address 0x0010->0x0020 -> mem_address stays 0x0010 until resp.
- Reset mid-op: assert reset during BUSY while mem_resp=1 -> next cycle all outputs 0, req_resp=0, state IDLE, RR pointer 0 (next winner among ports 1 and 2 is port1).
